// File: rtl/claw_level_ctrl.sv
// Gold Miner per-level claw controller: swing/descend/hold/retract, loot scoring, campaign sequencing.
// Latency: state and scores update 1 clk after inputs; collision flags and move_speed decode combinationally.
// Backpressure: none; pause freezes state, counter and scores and forces move_speed to 0.
module claw_level_ctrl #(
    parameter int NUM_LOOT        = 4,
    parameter int SCORE_W         = 12,
    parameter int SPEED_W         = 4,
    parameter int NUM_LEVELS      = 3,
    parameter int DEF_SPEED       = 4,
    parameter int MAX_DOWN_FRAMES = 90,
    parameter logic [NUM_LOOT*SCORE_W-1:0] LOOT_SCORE =
        {SCORE_W'(50), SCORE_W'(2), SCORE_W'(10), SCORE_W'(0)},
    parameter logic [NUM_LOOT*SPEED_W-1:0] LOOT_SPEED =
        {SPEED_W'(1), SPEED_W'(2), SPEED_W'(4), SPEED_W'(DEF_SPEED)}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          startOfFrame,
    input  logic                          start_level,
    input  logic                          pause,
    input  logic                          claw_dr,
    input  logic                          borders_dr,
    input  logic                          miner_dr,
    input  logic                          loot_dr,
    input  logic [$clog2(NUM_LOOT)-1:0]   loot_type,
    input  logic                          timer_ended,
    input  logic                          is_enter_pressed,
    input  logic [SCORE_W-1:0]            goal,
    input  logic                          claw_returned,
    output logic                          claw_collision,
    output logic                          loot_collision,
    output logic [SPEED_W-1:0]            move_speed,
    output logic [SCORE_W-1:0]            level_score,
    output logic [SCORE_W-1:0]            total_score,
    output logic [$clog2(NUM_LEVELS):0]   level_num,
    output logic                          SingleHitPulse,
    output logic                          level_ended,
    output logic                          level_won,
    output logic                          game_over,
    output logic                          game_won
);
    localparam int TW = $clog2(NUM_LOOT);
    localparam int LW = $clog2(NUM_LEVELS) + 1;
    localparam int CW = $clog2(MAX_DOWN_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE, SWING, DOWN, HOLD, BACK, LEVEL_END, GAME_OVER, GAME_WON
    } state_t;

    state_t          state;
    logic [TW-1:0]   type_q;
    logic [CW-1:0]   down_cnt;
    logic            loot_hit, any_hit, active, frozen, won_now;
    logic [SCORE_W-1:0] loot_pts;

    assign loot_hit       = claw_dr & loot_dr;
    assign any_hit        = loot_hit | (claw_dr & borders_dr) | (claw_dr & miner_dr);
    assign claw_collision = any_hit & SingleHitPulse;
    assign loot_collision = loot_hit & SingleHitPulse;
    assign active         = (state == SWING) || (state == DOWN) || (state == HOLD) || (state == BACK);
    assign frozen         = pause & active;
    assign loot_pts       = LOOT_SCORE[type_q*SCORE_W +: SCORE_W];
    assign won_now        = (level_score >= goal);

    always_comb begin
        move_speed = '0;
        if (!frozen) begin
            case (state)
                SWING, DOWN, HOLD: move_speed = SPEED_W'(DEF_SPEED);
                BACK:              move_speed = LOOT_SPEED[type_q*SPEED_W +: SPEED_W];
                default:           move_speed = '0;
            endcase
        end
    end

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            type_q         <= '0;
            down_cnt       <= '0;
            level_score    <= '0;
            total_score    <= '0;
            level_num      <= '0;
            SingleHitPulse <= 1'b0;
            level_ended    <= 1'b0;
            level_won      <= 1'b0;
            game_over      <= 1'b0;
            game_won       <= 1'b0;
        end else if (!frozen) begin
            case (state)
                IDLE: begin
                    level_score <= '0;
                    level_ended <= 1'b0;
                    level_won   <= 1'b0;
                    if (start_level) state <= SWING;
                end
                SWING: begin
                    type_q <= '0;
                    if (timer_ended) begin
                        state          <= LEVEL_END;
                        level_ended    <= 1'b1;
                        SingleHitPulse <= 1'b0;
                    end else if (is_enter_pressed) begin
                        state    <= DOWN;
                        down_cnt <= '0;
                    end
                end
                DOWN: begin
                    if (timer_ended) begin
                        state          <= LEVEL_END;
                        level_ended    <= 1'b1;
                        SingleHitPulse <= 1'b0;
                    end else if (any_hit) begin
                        state          <= HOLD;
                        SingleHitPulse <= 1'b1;
                        // Border/miner hits and out-of-table types retract empty.
                        type_q <= (loot_hit && (32'(loot_type) < NUM_LOOT)) ? loot_type : '0;
                    end else if (down_cnt >= CW'(MAX_DOWN_FRAMES)) begin
                        state  <= HOLD;
                        type_q <= '0;
                    end else if (startOfFrame) begin
                        down_cnt <= down_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (timer_ended) begin
                        state          <= LEVEL_END;
                        level_ended    <= 1'b1;
                        SingleHitPulse <= 1'b0;
                    end else if (startOfFrame) begin
                        state          <= BACK;
                        SingleHitPulse <= 1'b0;
                    end
                end
                BACK: begin
                    // A claw landing on the same cycle the timer expires still scores.
                    if (claw_returned) begin
                        level_score <= sat_add(level_score, loot_pts);
                        total_score <= sat_add(total_score, loot_pts);
                    end
                    if (timer_ended) begin
                        state          <= LEVEL_END;
                        level_ended    <= 1'b1;
                        SingleHitPulse <= 1'b0;
                    end else if (claw_returned) begin
                        state <= SWING;
                    end
                end
                LEVEL_END: begin
                    level_ended <= 1'b1;
                    level_won   <= won_now;
                    if (is_enter_pressed) begin
                        if (!won_now) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                        end else if (level_num == LW'(NUM_LEVELS - 1)) begin
                            state    <= GAME_WON;
                            game_won <= 1'b1;
                        end else begin
                            level_num <= level_num + 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                GAME_OVER, GAME_WON: begin
                    if (start_level) begin
                        state       <= SWING;
                        level_num   <= '0;
                        level_score <= '0;
                        total_score <= '0;
                        game_over   <= 1'b0;
                        game_won    <= 1'b0;
                        level_ended <= 1'b0;
                        level_won   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_claw_level_ctrl.sv
// Directed bench for claw_level_ctrl; a second instance with 6-bit scores shares the stimulus for saturation.
module tb_claw_level_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 0, start_level = 0, pause = 0;
    logic        claw_dr = 0, borders_dr = 0, miner_dr = 0, loot_dr = 0;
    logic [1:0]  loot_type = 0;
    logic        timer_ended = 0, is_enter_pressed = 0, claw_returned = 0;
    logic [11:0] goal = 12'd10;

    logic        claw_collision, loot_collision, SingleHitPulse;
    logic [3:0]  move_speed;
    logic [11:0] level_score, total_score;
    logic [2:0]  level_num;
    logic        level_ended, level_won, game_over, game_won;

    logic        cc6, lc6, shp6, le6, lw6, go6, gw6;
    logic [3:0]  ms6;
    logic [5:0]  ls6, ts6;
    logic [2:0]  ln6;

    int checks = 0;
    int errors = 0;
    int shp_seen;
    int coll_seen;

    localparam int S_IDLE = 0, S_SWING = 1, S_DOWN = 2, S_HOLD = 3, S_BACK = 4,
                   S_LEVEL_END = 5, S_GAME_OVER = 6, S_GAME_WON = 7;

    always #5 clk = ~clk;

    claw_level_ctrl dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_level(start_level),
        .pause(pause), .claw_dr(claw_dr), .borders_dr(borders_dr), .miner_dr(miner_dr),
        .loot_dr(loot_dr), .loot_type(loot_type), .timer_ended(timer_ended),
        .is_enter_pressed(is_enter_pressed), .goal(goal), .claw_returned(claw_returned),
        .claw_collision(claw_collision), .loot_collision(loot_collision), .move_speed(move_speed),
        .level_score(level_score), .total_score(total_score), .level_num(level_num),
        .SingleHitPulse(SingleHitPulse), .level_ended(level_ended), .level_won(level_won),
        .game_over(game_over), .game_won(game_won)
    );

    claw_level_ctrl #(.SCORE_W(6)) dut6 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_level(start_level),
        .pause(pause), .claw_dr(claw_dr), .borders_dr(borders_dr), .miner_dr(miner_dr),
        .loot_dr(loot_dr), .loot_type(loot_type), .timer_ended(timer_ended),
        .is_enter_pressed(is_enter_pressed), .goal(goal[5:0]), .claw_returned(claw_returned),
        .claw_collision(cc6), .loot_collision(lc6), .move_speed(ms6),
        .level_score(ls6), .total_score(ts6), .level_num(ln6),
        .SingleHitPulse(shp6), .level_ended(le6), .level_won(lw6),
        .game_over(go6), .game_won(gw6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic enter_pulse();
        is_enter_pressed = 1'b1;
        tick();
        is_enter_pressed = 1'b0;
    endtask

    task automatic start_pulse();
        start_level = 1'b1;
        tick();
        start_level = 1'b0;
    endtask

    task automatic timer_pulse();
        timer_ended = 1'b1;
        tick();
        timer_ended = 1'b0;
    endtask

    // Fire, grab loot of type t, retract and land back in SWING.
    task automatic grab(input logic [1:0] t);
        enter_pulse();
        claw_dr = 1'b1; loot_dr = 1'b1; loot_type = t;
        tick();
        claw_dr = 1'b0; loot_dr = 1'b0;
        sof_pulse();
        claw_returned = 1'b1;
        tick();
        claw_returned = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        reset = 1'b0;
        tick();
        check("rst_state", 32'(dut.state), S_IDLE);
        check("rst_speed", 32'(move_speed), 0);
        check("rst_lscore", 32'(level_score), 0);
        check("rst_lnum", 32'(level_num), 0);
        check("rst_shp", 32'(SingleHitPulse), 0);

        // Gold hit
        start_pulse();
        check("swing_state", 32'(dut.state), S_SWING);
        check("swing_speed", 32'(move_speed), 4);
        enter_pulse();
        check("down_state", 32'(dut.state), S_DOWN);
        claw_dr = 1'b1; loot_dr = 1'b1; loot_type = 2'd1;
        tick();
        check("gold_state", 32'(dut.state), S_HOLD);
        check("gold_loot_coll", 32'(loot_collision), 1);
        check("gold_claw_coll", 32'(claw_collision), 1);
        claw_dr = 1'b0; loot_dr = 1'b0;
        sof_pulse();
        check("gold_back", 32'(dut.state), S_BACK);
        check("gold_shp_clr", 32'(SingleHitPulse), 0);
        check("gold_speed", 32'(move_speed), 4);
        claw_returned = 1'b1; tick(); claw_returned = 1'b0;
        check("gold_lscore", 32'(level_score), 10);
        check("gold_tscore", 32'(total_score), 10);
        check("gold_to_swing", 32'(dut.state), S_SWING);

        // Border-only hit
        enter_pulse();
        claw_dr = 1'b1; borders_dr = 1'b1;
        tick();
        check("border_claw_coll", 32'(claw_collision), 1);
        check("border_loot_coll", 32'(loot_collision), 0);
        claw_dr = 1'b0; borders_dr = 1'b0;
        sof_pulse();
        check("border_speed", 32'(move_speed), 4);
        claw_returned = 1'b1; tick(); claw_returned = 1'b0;
        check("border_score", 32'(level_score), 10);

        // Rock retract, timer and landing on the same cycle
        enter_pulse();
        claw_dr = 1'b1; loot_dr = 1'b1; loot_type = 2'd2;
        tick();
        claw_dr = 1'b0; loot_dr = 1'b0;
        sof_pulse();
        check("rock_speed", 32'(move_speed), 2);
        claw_returned = 1'b1; timer_ended = 1'b1;
        tick();
        claw_returned = 1'b0; timer_ended = 1'b0;
        check("same_cyc_lscore", 32'(level_score), 12);
        check("same_cyc_tscore", 32'(total_score), 12);
        check("same_cyc_state", 32'(dut.state), S_LEVEL_END);
        check("lend_ended", 32'(level_ended), 1);
        check("lend_speed", 32'(move_speed), 0);
        tick();
        check("lend_won", 32'(level_won), 1);
        enter_pulse();
        check("lvl1_num", 32'(level_num), 1);
        check("lvl1_idle", 32'(dut.state), S_IDLE);
        tick();
        check("idle_lscore_clr", 32'(level_score), 0);
        check("idle_ended_clr", 32'(level_ended), 0);

        // Level 1: descent timeout
        start_pulse();
        enter_pulse();
        shp_seen = 0;
        for (int i = 0; i < 89; i++) begin
            sof_pulse();
            if (SingleHitPulse) shp_seen++;
        end
        tick(3);
        check("timeout_not_yet", 32'(dut.state), S_DOWN);
        sof_pulse();
        tick();
        check("timeout_hold", 32'(dut.state), S_HOLD);
        if (SingleHitPulse) shp_seen++;
        sof_pulse();
        check("timeout_back", 32'(dut.state), S_BACK);
        check("timeout_speed", 32'(move_speed), 4);
        claw_returned = 1'b1; tick(); claw_returned = 1'b0;
        check("timeout_score", 32'(level_score), 0);
        check("timeout_no_shp", 32'(shp_seen), 0);

        // Pause during descent with hits and timer present
        enter_pulse();
        pause = 1'b1;
        tick();
        check("pause_speed", 32'(move_speed), 0);
        claw_dr = 1'b1; loot_dr = 1'b1; loot_type = 2'd3;
        coll_seen = 0;
        for (int i = 0; i < 100; i++) begin
            sof_pulse();
            if (claw_collision || loot_collision) coll_seen++;
        end
        timer_pulse();
        check("pause_state", 32'(dut.state), S_DOWN);
        check("pause_cnt", 32'(dut.down_cnt), 0);
        check("pause_no_coll", 32'(coll_seen), 0);
        pause = 1'b0;
        tick();
        check("resume_hit", 32'(dut.state), S_HOLD);
        check("resume_loot_coll", 32'(loot_collision), 1);
        claw_dr = 1'b0; loot_dr = 1'b0;
        sof_pulse();
        check("gold50_speed", 32'(move_speed), 1);
        claw_returned = 1'b1; tick(); claw_returned = 1'b0;
        check("l1_lscore", 32'(level_score), 50);
        check("l1_tscore", 32'(total_score), 62);
        timer_pulse();
        tick();
        enter_pulse();
        check("lvl2_num", 32'(level_num), 2);

        // Level 2, final level
        tick();
        start_pulse();
        grab(2'd1);
        timer_pulse();
        tick();
        enter_pulse();
        check("game_won", 32'(game_won), 1);
        check("game_won_state", 32'(dut.state), S_GAME_WON);
        check("game_won_speed", 32'(move_speed), 0);
        check("game_won_total", 32'(total_score), 72);

        // Restart, lose level 0
        start_pulse();
        check("restart_lnum", 32'(level_num), 0);
        check("restart_total", 32'(total_score), 0);
        check("restart_won_clr", 32'(game_won), 0);
        timer_pulse();
        tick();
        enter_pulse();
        check("game_over", 32'(game_over), 1);
        check("game_over_state", 32'(dut.state), S_GAME_OVER);
        start_pulse();
        check("over_restart_clr", 32'(game_over), 0);
        check("over_restart_state", 32'(dut.state), S_SWING);
        check("over_restart_lscore", 32'(level_score), 0);

        // Saturation: 6-bit instance clips, 12-bit instance does not
        reset = 1'b1; tick(); reset = 1'b0; tick();
        start_pulse();
        grab(2'd3);
        check("sat1_6b", 32'(ls6), 50);
        grab(2'd3);
        check("sat2_6b", 32'(ls6), 63);
        check("sat2_6b_total", 32'(ts6), 63);
        grab(2'd3);
        check("sat3_6b", 32'(ls6), 63);
        check("sat3_12b", 32'(level_score), 150);

        // Reset mid-retract
        enter_pulse();
        claw_dr = 1'b1; loot_dr = 1'b1; loot_type = 2'd1;
        tick();
        claw_dr = 1'b0; loot_dr = 1'b0;
        sof_pulse();
        #2 reset = 1'b1;
        #1;
        check("midrst_state", 32'(dut.state), S_IDLE);
        check("midrst_score", 32'(level_score), 0);
        check("midrst_speed", 32'(move_speed), 0);
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/claw_level_ctrl.md
Name: claw_level_ctrl

Overview:
Parametrised per-level game controller for the Gold Miner claw. It sequences swing / descend / hold / retract and classifies claw collisions against a configurable loot table. It accumulates saturating level and total scores and enforces a descent timeout. It also supports pause and runs a multi-level campaign with goal check, level advance, win and game-over. It sits between the object drawing-request mux, the level timer and the keypad decoder, and drives the claw/loot movers and the score display.

Parameters:
NUM_LOOT, 4, number of loot types; type 0 = nothing/default
SCORE_W, 12, width of level and total score
SPEED_W, 4, width of move_speed
NUM_LEVELS, 3, levels in a campaign (>=1)
DEF_SPEED, 4, claw speed when empty / descending
MAX_DOWN_FRAMES, 90, frames allowed in descent before forced retract
LOOT_SCORE, {0,10,2,50}, per-type score (packed, SCORE_W each, index = loot type)
LOOT_SPEED, {DEF_SPEED,4,2,1}, per-type retract speed (packed, SPEED_W each)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-clk pulse per frame
start_level  in  1  start / restart request
pause  in  1  level-sensitive freeze
claw_dr, borders_dr, miner_dr, loot_dr  in  1 each  drawing requests
loot_type  in  $clog2(NUM_LOOT)  type of loot currently drawn
timer_ended  in  1  level timer expired
is_enter_pressed  in  1  fire claw / confirm
goal  in  SCORE_W  level goal
claw_returned  in  1  claw back at pivot
claw_collision  out  1  any claw hit, one per hit
loot_collision  out  1  claw-loot hit, one per hit
move_speed  out  SPEED_W  claw/loot speed
level_score, total_score  out  SCORE_W each
level_num  out  $clog2(NUM_LEVELS)+1  current level, 0-based
SingleHitPulse  out  1  hit-window flag
level_ended, level_won, game_over, game_won  out  1 each  status

Behaviour:
- Reset values: all outputs 0; state IDLE; latched type 0; frame counter 0.
- Combinational collision terms:
  - loot_hit = claw_dr & loot_dr.
  - any_hit = loot_hit | (claw_dr & borders_dr) | (claw_dr & miner_dr).
  - claw_collision = any_hit & SingleHitPulse.
  - loot_collision = loot_hit & SingleHitPulse.
- States: IDLE, SWING, DOWN, HOLD, BACK, LEVEL_END, GAME_OVER, GAME_WON.
- IDLE:
  - level_score <= 0; level_ended/level_won <= 0.
  - start_level -> SWING.
- SWING:
  - move_speed = DEF_SPEED; latched type <= 0.
  - is_enter_pressed -> DOWN; down-frame counter cleared.
- DOWN:
  - move_speed = DEF_SPEED; counter increments on startOfFrame.
  - any_hit -> HOLD, SingleHitPulse <= 1. If loot_hit, latch loot_type; a type >= NUM_LOOT latches 0.
  - If no hit and the counter reaches MAX_DOWN_FRAMES -> HOLD with type 0. SingleHitPulse stays 0 on timeout.
- HOLD: on startOfFrame, SingleHitPulse <= 0 -> BACK.
- BACK:
  - move_speed = LOOT_SPEED[type].
  - claw_returned -> add LOOT_SCORE[type] to level_score and total_score, then -> SWING.
  - Both adds saturate at 2^SCORE_W-1.
- timer_ended in SWING/DOWN/HOLD/BACK -> LEVEL_END.
  - In BACK with claw_returned in the same cycle, the score is credited first, then -> LEVEL_END.
  - SingleHitPulse is cleared on entry.
- LEVEL_END:
  - level_ended=1; move_speed=0; level_won = (level_score >= goal).
  - On is_enter_pressed:
    - Won and level_num = NUM_LEVELS-1 -> GAME_WON.
    - Won otherwise -> level_num+1, then IDLE.
    - Lost -> GAME_OVER.
- GAME_OVER / GAME_WON:
  - game_over or game_won = 1; move_speed = 0.
  - start_level -> level_num, total_score, level_score <= 0; -> SWING.
- pause = 1 in SWING/DOWN/HOLD/BACK:
  - State, counter and scores hold; move_speed forced 0.
  - Collisions and timer_ended are ignored while paused.
  - HOLD does not consume startOfFrame while paused.
- Simultaneous-event priority: reset > pause > timer_ended > collision > timeout > enter.
- Reset mid-operation returns immediately to the reset values.
- Latency: all state and register updates take 1 clk; collision outputs are combinational.

Test Plan:
- Gold hit: start, enter, loot_dr & claw_dr with type=1 in DOWN -> loot_collision=1 for 1 frame, move_speed 4. claw_returned -> level_score=10, total_score=10, state SWING.
- Border-only hit: claw_dr & borders_dr -> claw_collision=1, loot_collision=0. Retract at DEF_SPEED; score unchanged.
- Timeout: no hit for 90 startOfFrame pulses -> HOLD then BACK, type 0, SingleHitPulse never 1, score +0.
- Saturation: SCORE_W=6, repeated type-3 grabs (50) -> score stops at 63.
- Same-cycle timer: timer_ended & claw_returned in BACK with rock -> score +2, state LEVEL_END.
- Campaign: goal=10 met on levels 0-2 with enter -> level_num 1, 2, then game_won=1. Separate run below goal -> game_over=1; start_level -> scores and level_num 0.
- Pause: pause=1 in DOWN for 100 frames with hits -> no collision, counter frozen, move_speed 0; release -> resumes DOWN.
